// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: default width,
// digit encoding and controller states.
package booth_pkg;

   localparam int W_DEFAULT = 8;

   typedef struct packed {
      logic single;
      logic double;
      logic negate;
   } booth_digit_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/ready/done handshake and operand/product bus of the Booth multiplier.
interface booth_mult_seq_if #(parameter int W = booth_pkg::W_DEFAULT);
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           ready;
   logic           done;
   logic [2*W-1:0] p;

   modport master (output start, a, b, input ready, done, p);
   modport slave  (input start, a, b, output ready, done, p);
endinterface

// File: rtl/booth_digit_enc.sv
// Combinational radix-4 Booth recoder: one 3-bit multiplier window to a digit.
module booth_digit_enc
   import booth_pkg::*;
(
   input  logic [2:0]   win,
   output booth_digit_t dig
);

   assign dig.single = win[0] ^ win[1];
   assign dig.double = (win[2] & ~win[1] & ~win[0]) | (~win[2] & win[1] & win[0]);
   assign dig.negate = win[2];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one digit per clock through a single
// shared recoder and adder, signed 2W-bit product after W/2 RUN cycles.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   booth_mult_seq_if.slave  bus
);

   localparam int D  = W / 2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;

   state_t         state;
   logic [2*W-1:0] mcand;
   logic [W+1:0]   breg;
   logic [2*W-1:0] acc;
   logic [CW-1:0]  cnt;
   logic           ready_q;
   logic           done_q;
   logic [2*W-1:0] p_q;

   booth_digit_t   dig;
   logic [2*W-1:0] mag;
   logic [2*W-1:0] pp;
   logic [2*W-1:0] acc_nxt;

   booth_digit_enc u_enc (
      .win (breg[2:0]),
      .dig (dig)
   );

   // Magnitude is kept at 2W so 2*mcand of -2^(W-1) cannot wrap; window 111
   // negates a zero magnitude and must contribute exactly zero.
   always_comb begin
      mag = '0;
      if (dig.single)
         mag = mcand;
      else if (dig.double)
         mag = mcand << 1;
      pp      = dig.negate ? (~mag + 1'b1) : mag;
      acc_nxt = acc + (pp << {cnt, 1'b0});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         p_q     <= '0;
         acc     <= '0;
         cnt     <= '0;
         mcand   <= '0;
         breg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  mcand   <= {{W{bus.a[W-1]}}, bus.a};
                  breg    <= {bus.b[W-1], bus.b, 1'b0};
                  acc     <= '0;
                  cnt     <= '0;
                  ready_q <= 1'b0;
                  state   <= RUN;
               end
            end
            RUN: begin
               acc  <= acc_nxt;
               breg <= {{2{breg[W+1]}}, breg[W+1:2]};
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(D - 1)) begin
                  p_q    <= acc_nxt;
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               done_q  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.done  = done_q;
   assign bus.p     = p_q;

endmodule
